// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Command field in rx_data[9:8]; the RAM decodes it.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the RAM-side rx/tx handshake of the SPI slave front-end.
interface spi_slave_if_if #(
    parameter int unsigned MEM_WIDTH = 8
);
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic [MEM_WIDTH+1:0] rx_data;
    logic                 rx_valid;
    logic [MEM_WIDTH-1:0] tx_data;
    logic                 tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if_tx_serializer.sv
// Loads one RAM read byte and shifts it out MSB first on MISO, then idles at 0.
module spi_tx_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_miso,
    output logic             o_busy,
    output logic             o_done
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_miso;
    logic             r_busy;
    logic             r_done;

    // MSB goes straight to MISO on load; r_shift holds the remaining bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_load) begin
            r_miso  <= i_data[WIDTH-1];
            r_shift <= i_data[WIDTH-2:0];
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_miso <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_miso  <= r_shift[WIDTH-2];
                r_shift <= {r_shift[WIDTH-3:0], 1'b0};
                r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

    assign o_miso = r_miso;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front-end: deserialises 11-bit frames into RAM command
// words and serialises the RAM read byte back on MISO.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_if_if.slave  bus
);
    localparam int unsigned WORD_W = MEM_WIDTH + 2;
    localparam int unsigned CNT_W  = $clog2(FRAME_BITS);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WORD_W-2:0]   r_shift;
    logic [WORD_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_word_done;
    logic                r_rd_addr_seen;

    logic                w_shifting;
    logic                w_last_bit;
    logic                w_tx_load;
    logic                w_tx_clear;
    logic                w_tx_busy;
    logic                w_tx_done;
    logic                w_miso;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_shifting   = 1'b0;
        w_last_bit   = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_clear   = bus.SS_n || (r_state == IDLE);

        case (r_state)
            IDLE: begin
                if (!bus.SS_n) begin
                    w_next_state = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    w_next_state = IDLE;
                end else if (!bus.MOSI) begin
                    w_next_state = WRITE;
                end else if (r_rd_addr_seen) begin
                    w_next_state = READ_DATA;
                end else begin
                    w_next_state = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    w_next_state = IDLE;
                end else begin
                    w_shifting = !r_word_done;
                    w_last_bit = !r_word_done && (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
                    // Only the first tx_valid after the word is accepted per frame.
                    w_tx_load  = (r_state == READ_DATA) && r_word_done && bus.tx_valid
                                 && !w_tx_busy && !w_tx_done;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Word bits collect in r_shift so an aborted frame leaves rx_data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_word_done    <= 1'b0;
            r_rd_addr_seen <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (bus.SS_n || (r_state == IDLE)) begin
                r_bit_cnt   <= '0;
                r_word_done <= 1'b0;
            end else if (w_shifting) begin
                r_shift <= {r_shift[WORD_W-3:0], bus.MOSI};
                if (w_last_bit) begin
                    r_rx_data   <= {r_shift, bus.MOSI};
                    r_rx_valid  <= 1'b1;
                    r_word_done <= 1'b1;
                    r_bit_cnt   <= '0;
                    if (r_state == READ_ADD) begin
                        r_rd_addr_seen <= 1'b1;
                    end else if (r_state == READ_DATA) begin
                        r_rd_addr_seen <= 1'b0;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    spi_tx_serializer #(
        .WIDTH (MEM_WIDTH)
    ) u_tx_serializer (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (w_tx_clear),
        .i_load  (w_tx_load),
        .i_data  (bus.tx_data),
        .o_miso  (w_miso),
        .o_busy  (w_tx_busy),
        .o_done  (w_tx_done)
    );

    assign bus.MISO     = w_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: stimulus queues expected per-cycle
// outputs and rx words; a negedge monitor pops and compares.
module tb_spi_slave_if;
    import spi_pkg::*;

    localparam int unsigned MW = 8;

    logic clk = 1'b0;
    logic rst_n;

    spi_slave_if_if #(.MEM_WIDTH(MW)) bus ();

    spi_slave_if #(.MEM_WIDTH(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic miso;
        logic rxv;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  rx_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        mon_e;
    logic [9:0]  mon_w;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock cycle of stimulus plus the outputs expected during that cycle.
    task automatic cyc(input logic ss, input logic mosi, input logic txv,
                       input logic [7:0] txd, input logic e_miso, input logic e_rxv);
        @(posedge clk);
        #1;
        bus.SS_n     = ss;
        bus.MOSI     = mosi;
        bus.tx_valid = txv;
        bus.tx_data  = txd;
        exp_q.push_back('{miso: e_miso, rxv: e_rxv});
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // ncyc cycles with SS_n low (c0..ncyc-1); txc is the tx_valid cycle or -1;
    // dbl adds a second tx_valid two cycles later; rd expects a MISO readback.
    task automatic frame(input logic sel, input logic [9:0] word, input int ncyc,
                         input int txc, input logic [7:0] txd, input logic dbl, input logic rd);
        if (ncyc > 12) rx_q.push_back(word);
        for (int c = 0; c < ncyc; c++) begin
            logic       m;
            logic       tv;
            logic       em;
            logic [7:0] td;
            m  = (c == 1) ? sel : ((c >= 2 && c <= 11) ? word[11 - c] : 1'b1);
            tv = (txc >= 0) && ((c == txc) || (dbl && c == txc + 2));
            td = (dbl && c == txc + 2) ? ~txd : txd;
            em = (rd && txc >= 0 && c > txc && c <= txc + 8) ? txd[7 - (c - txc - 1)] : 1'b0;
            cyc(1'b0, m, tv, td, em, c == 12);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        #1;
        check("rst_miso", {31'd0, bus.MISO}, 32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_rx_data", {22'd0, bus.rx_data}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("miso", {31'd0, bus.MISO}, {31'd0, mon_e.miso});
                    check("rx_valid", {31'd0, bus.rx_valid}, {31'd0, mon_e.rxv});
                end
                if (bus.rx_valid) begin
                    if (rx_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rx_word: unexpected rx_valid with rx_data=%0h, required no word", bus.rx_data);
                    end else begin
                        mon_w = rx_q.pop_front();
                        check("rx_data", {22'd0, bus.rx_data}, {22'd0, mon_w});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        #12;
        check("reset_miso", {31'd0, bus.MISO}, 32'd0);
        check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_rx_data", {22'd0, bus.rx_data}, 32'd0);
        #10 rst_n = 1'b1;
        idle();

        // Write address and write data
        frame(1'b0, {CMD_WR_ADDR, 8'hA5}, 15, -1, 8'h00, 1'b0, 1'b0);
        idle();
        frame(1'b0, {CMD_WR_DATA, 8'h3C}, 15, -1, 8'h00, 1'b0, 1'b0);
        idle();

        // SS_n low for one IDLE cycle only
        frame(1'b0, 10'h000, 1, -1, 8'h00, 1'b0, 1'b0);
        idle();

        // Read address (stray tx_valid ignored), then read data with readback
        frame(1'b1, {CMD_RD_ADDR, 8'hA5}, 23, 13, 8'h99, 1'b0, 1'b0);
        idle();
        frame(1'b1, {CMD_RD_DATA, 8'h00}, 24, 13, 8'hC3, 1'b1, 1'b1);
        idle();

        // rd_addr_seen cleared: select 1 is a read-address frame again
        frame(1'b1, {CMD_RD_ADDR, 8'h55}, 23, 13, 8'hFF, 1'b0, 1'b0);
        idle();

        // Abort after 5 word bits; rx_data keeps the last word
        frame(1'b0, {CMD_WR_DATA, 8'hF0}, 7, -1, 8'h00, 1'b0, 1'b0);
        idle();
        check("abort_rx_data_held", {22'd0, bus.rx_data}, {22'd0, CMD_RD_ADDR, 8'h55});
        frame(1'b0, 10'h1FF, 15, -1, 8'h00, 1'b0, 1'b0);
        idle();

        // Async reset during MISO bit 3 of a readback (rd_addr_seen still set)
        frame(1'b1, {CMD_RD_DATA, 8'h12}, 19, 13, 8'h5C, 1'b0, 1'b1);
        pulse_reset();
        idle();
        frame(1'b1, {CMD_RD_ADDR, 8'h40}, 23, 13, 8'h5A, 1'b0, 1'b0);
        idle();

        // Reset while rd_addr_seen is set clears it
        pulse_reset();
        idle();
        frame(1'b1, {CMD_RD_ADDR, 8'h41}, 23, 13, 8'h77, 1'b0, 1'b0);
        idle();

        // Read data with no tx_valid for 20 cycles
        frame(1'b1, {CMD_RD_DATA, 8'h00}, 33, -1, 8'h00, 1'b0, 1'b0);
        idle();
        frame(1'b1, {CMD_RD_ADDR, 8'h0F}, 23, 13, 8'hE7, 1'b0, 1'b0);
        idle();
        idle();

        @(negedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 32'd0);
        check("rx_queue_drained", rx_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
Serial front-end of the SPI slave with single-port RAM. It receives MOSI frames under SS_n and deserialises them into 10-bit command words. Each word is presented to the RAM as rx_data/rx_valid. The block captures the RAM read byte on tx_data/tx_valid and shifts it back out on MISO. SPI mode 0: MOSI is sampled and MISO is updated on posedge clk, with SCK treated as clk.

Parameters:
MEM_WIDTH, 8, RAM data width; rx_data width is MEM_WIDTH+2, tx_data width is MEM_WIDTH.

Ports:
clk  input  1  system/SPI clock
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low; high ends or aborts a frame
MOSI  input  1  serial data in, MSB first
MISO  output  1  serial data out, MSB first
rx_data  output  MEM_WIDTH+2  deserialised word {cmd[1:0], payload[7:0]} to RAM din
rx_valid  output  1  one-cycle strobe, rx_data valid
tx_data  input  MEM_WIDTH  RAM read byte
tx_valid  input  1  strobe, tx_data valid

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0.
- States:
  - IDLE: SS_n low -> CHK_CMD.
  - CHK_CMD:
    - samples MOSI (frame bit 0, select bit);
    - 0 -> WRITE;
    - 1 and rd_addr_seen=0 -> READ_ADD;
    - 1 and rd_addr_seen=1 -> READ_DATA.
  - WRITE, READ_ADD, READ_DATA: the next 10 cycles shift MOSI into rx_data MSB first (rx_data[9] first). The counter runs 0..9.
- Frame length: 11 bits (select bit + 10 word bits).
- rx_valid:
  - Registered; high for exactly one cycle, on the cycle after the 10th word bit is sampled.
  - rx_data is held stable from that cycle until the next frame's shifting begins.
  - The word is passed unchanged; a mismatch between the select bit and rx_data[9:8] is not checked (RAM decodes).
- rd_addr_seen: set when a READ_ADD frame completes (rx_valid issued); cleared when a READ_DATA frame issues rx_valid.
- Frame completion:
  - After rx_valid, WRITE and READ_ADD wait in state until SS_n high -> IDLE. Extra MOSI bits are ignored.
  - READ_DATA after rx_valid waits for tx_valid. On the tx_valid cycle it latches tx_data.
- Readback: MISO = tx_data[7] on the next cycle, then bits 6..0 on the following 7 cycles (8 cycles total). After that MISO=0.
  - The state holds until SS_n high. A second tx_valid in the same frame is ignored.
  - If tx_valid never arrives, MISO stays 0.
- SS_n high in any non-IDLE state:
  - Next state is IDLE; the counter clears and MISO becomes 0.
  - No rx_valid for an incomplete word; rd_addr_seen is unchanged.
  - An aborted readback is not resumed.
- SS_n must be high at least 1 cycle between frames. SS_n low for a single IDLE cycle only enters CHK_CMD.
- Latency: SS_n falling edge cycle = c0 (IDLE -> CHK_CMD). Select bit at c1, word bits c2..c11, rx_valid at c12. Given RAM tx_valid at c13, MISO bit7 at c14 and bit0 at c21.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_BITS=10.
- One natural sub-module, spi_tx_serializer: loads on tx_valid and shifts 8 bits to MISO with a done flag. Everything else is flat in spi_slave_if.

Test Plan:
- Write address: SS_n low, MOSI 0 then 00_1010_0101 -> rx_data=10'h0A5, rx_valid one cycle at c12, MISO stays 0, rd_addr_seen=0.
- Write data: frame 0 then 01_0011_1100 -> rx_data=10'h13C, single rx_valid pulse; a following SS_n high returns to IDLE.
- Read address then read data:
  - frame 1 then 10_1010_0101 -> rx_data=10'h2A5, rd_addr_seen=1;
  - next frame 1 then 11_0000_0000 goes to READ_DATA, rx_data=10'h300;
  - tx_valid with tx_data=8'hC3 the cycle after -> MISO 1,1,0,0,0,0,1,1 on the next 8 cycles; rd_addr_seen=0.
- Abort: SS_n high after 5 word bits of a WRITE frame -> IDLE next cycle, no rx_valid, rx_data unchanged; the next full frame decodes correctly.
- Async reset mid-readback: rst_n low during MISO bit 3 -> immediately MISO=0, rx_valid=0, state IDLE, rd_addr_seen=0; a subsequent select bit 1 goes to READ_ADD.
- Read data with no tx_valid: READ_DATA frame completes and tx_valid is held 0 for 20 cycles -> MISO=0 throughout; SS_n high -> IDLE.
